// File: rtl/vga_capture.sv
// vga_capture: samples a VGA-format stream, measures line/frame timing,
// locks after LOCK_FRAMES consecutive good frames and then emits one
// frame-buffer write per active pixel.
// Optional feature macro: VGA_CAPTURE_CRC_EN (per-frame CRC-16-CCITT of written data).
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [7:0]  color_in,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        locked,
  output logic        frame_done,
  output logic        err,
  output logic        overflow,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic [2:0]  good_cnt, good_d;
  logic        err_d, fdone_d;

  logic        hs_q, vs_q, bl_q;      // S1 input register
  logic        hs_p, vs_p, bl_p;      // previous S1 value for edge detect
  logic [7:0]  col_q;
  logic        hfall, vfall, bfall;

  logic [9:0]  h_meas, v_meas, lines_n;
  logic        lines_ok, line_good, frame_len_good, frame_good;

  logic [9:0]  x, y;
  logic [18:0] addr;
  logic        pix_in, wr_go;

  assign hfall = hs_p & ~hs_q;
  assign vfall = vs_p & ~vs_q;
  assign bfall = bl_p & ~bl_q;

  // A coincident hfall is counted into the frame that this vfall closes.
  assign lines_n        = v_meas + {9'd0, hfall};
  assign line_good      = (h_meas == 10'(H_TOTAL));
  assign frame_len_good = (lines_n == 10'(V_TOTAL));
  assign frame_good     = frame_len_good && lines_ok && !(hfall && !line_good);

  assign pix_in = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
  assign wr_go  = (state_q == LOCKED) && !vfall && bl_q && pix_in;
  assign locked = (state_q == LOCKED);

  // Input register and edge-detect history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {hs_q, vs_q, bl_q, hs_p, vs_p, bl_p} <= '0;
      col_q <= '0;
    end else begin
      {hs_q, vs_q, bl_q} <= {hsync, vsync, blank};
      {hs_p, vs_p, bl_p} <= {hs_q, vs_q, bl_q};
      col_q <= color_in;
    end
  end

  // Line and frame measurement; lines_ok tracks whether every line of the frame was H_TOTAL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_meas      <= '0;
      v_meas      <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      lines_ok    <= 1'b0;
    end else begin
      if (hfall) begin
        h_meas   <= 10'd1;
        line_len <= h_meas;
      end else if (h_meas != 10'h3FF) begin
        h_meas <= h_meas + 10'd1;
      end
      if (vfall) begin
        frame_lines <= lines_n;
        v_meas      <= '0;
        lines_ok    <= 1'b1;
      end else if (hfall) begin
        v_meas <= v_meas + 10'd1;
        if (!line_good) lines_ok <= 1'b0;
      end
    end
  end

  // FSM state, good-frame counter and one-cycle pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      good_cnt   <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt   <= good_d;
      err        <= err_d;
      frame_done <= fdone_d;
    end
  end

  // Next-state logic: lock after LOCK_FRAMES good frames, drop on any bad line/frame.
  always_comb begin
    state_d = state_q;
    good_d  = good_cnt;
    err_d   = 1'b0;
    fdone_d = 1'b0;
    case (state_q)
      SEARCH: if (vfall) begin
        state_d = MEASURE;
        good_d  = '0;
      end
      MEASURE: if (vfall) begin
        if (!frame_good) begin
          good_d = '0;
        end else if (good_cnt + 3'd1 == 3'(LOCK_FRAMES)) begin
          state_d = LOCKED;
          good_d  = '0;
        end else begin
          good_d = good_cnt + 3'd1;
        end
      end
      LOCKED: begin
        if ((hfall && !line_good) || (vfall && !frame_len_good)) begin
          state_d = SEARCH;
          err_d   = 1'b1;
        end else if (vfall) begin
          fdone_d = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Pixel capture: running address counter, coordinates restart on vfall / blank fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      x_out    <= '0;
      y_out    <= '0;
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      overflow <= 1'b0;
    end else begin
      wr_en <= wr_go;
      if (vfall) begin
        x        <= '0;
        y        <= '0;
        addr     <= '0;
        overflow <= 1'b0;
      end else if (state_q == LOCKED) begin
        if (bl_q) begin
          if (pix_in) begin
            wr_addr <= addr;
            wr_data <= col_q;
            x_out   <= x;
            y_out   <= y;
            x       <= x + 10'd1;
            addr    <= addr + 19'd1;
          end else begin
            overflow <= 1'b1;
          end
        end else if (bfall) begin
          x <= '0;
          y <= y + 10'd1;
        end
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_acc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  // CRC over every issued write; latched and reinitialised at each vfall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= '0;
    end else if (vfall) begin
      frame_crc <= crc_acc;
      crc_acc   <= 16'hFFFF;
    end else if (wr_go) begin
      crc_acc <= crc_step(crc_acc, col_q);
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scaled-down VGA stream (24x14 total, 10x8 active) driving
// vga_capture; expected writes are queued by the stimulus and popped by a monitor.
module tb_vga_capture;
  localparam int HT = 24, VT = 14, HA = 10, VA = 8;

  logic        clock = 1'b0, reset = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b0;
  logic [7:0]  color_in = '0;
  logic        wr_en, locked, frame_done, err, overflow;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic [9:0]  x_out, y_out, line_len, frame_lines;
  logic [15:0] frame_crc;

  vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync), .blank(blank),
    .color_in(color_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .x_out(x_out), .y_out(y_out), .locked(locked), .frame_done(frame_done),
    .err(err), .overflow(overflow), .line_len(line_len), .frame_lines(frame_lines),
    .frame_crc(frame_crc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
    logic [9:0]  x;
    logic [9:0]  y;
  } wr_t;

  wr_t exp_q[$];
  int checks = 0, failures = 0, wr_cnt = 0, fd_cnt = 0, err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_zeros(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (wr_en) begin
        wr_t got, e;
        got = {wr_addr, wr_data, x_out, y_out};
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: addr=%0d data=%h x=%0d y=%0d, none expected",
                   wr_addr, wr_data, x_out, y_out);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL write: got addr=%0d data=%h x=%0d y=%0d expected addr=%0d data=%h x=%0d y=%0d",
                     got.a, got.d, got.x, got.y, e.a, e.d, e.x, e.y);
          end
        end
      end
      if (frame_done) fd_cnt++;
      if (err) err_cnt++;
    end
  end

  // One frame: hsync low at h=12..15, vsync falls together with hsync on line 10.
  task automatic run_frame(input int cap_lines, input int stretch_line, input int ovf_line,
                           input int rst_line, input bit zero_col);
    bit rst_done;
    rst_done = 1'b0;
    for (int l = 0; l < VT; l++) begin
      for (int h = 0; h < ((l == stretch_line) ? HT + 1 : HT); h++) begin
        @(negedge clock);
        if (l == rst_line && h == 5) rst_done = 1'b1;
        if (l == rst_line && h == 8) reset = 1'b0;
        hsync    = !(h >= 12 && h < 16);
        vsync    = !((l == 10 && h >= 12) || l == 11 || (l == 12 && h < 12));
        blank    = (l < VA) && (h < ((l == ovf_line) ? HA + 1 : HA));
        color_in = zero_col ? 8'h00 : 8'(h ^ l);
        if (blank && !rst_done && l < cap_lines && h < HA)
          exp_q.push_back({19'(l * HA + h), color_in, 10'(h), 10'(l)});
        if (stretch_line >= 0 && l == stretch_line + 1 && h == 20)
          check("stretched_line_len", line_len, HT + 1);
        if (ovf_line >= 0 && l == 9 && h == 0)
          check("overflow_set", overflow, 1);
        if (l == rst_line && h == 5) begin
          #2 reset = 1'b1;
          exp_q.delete();
          #1;
          check("midframe_reset_write", {wr_en, wr_addr, wr_data, x_out, y_out}, 0);
          check("midframe_reset_status",
                {locked, frame_done, err, overflow, line_len, frame_lines, frame_crc}, 0);
        end
      end
    end
    check("queue_drained", exp_q.size(), 0);
    if (ovf_line >= 0) check("overflow_cleared", overflow, 0);
  endtask

  initial begin
    int w0, f0, e0;
    logic [15:0] exp_crc;
    repeat (3) @(posedge clock);
    #1;
    check("reset_write", {wr_en, wr_addr, wr_data, x_out, y_out}, 0);
    check("reset_status", {locked, frame_done, err, overflow, line_len, frame_lines, frame_crc}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Lock acquisition: third vfall enters LOCKED.
    run_frame(0, -1, -1, -1, 0);  check("lock_vfall1", locked, 0);
    run_frame(0, -1, -1, -1, 0);  check("lock_vfall2", locked, 0);
    run_frame(0, -1, -1, -1, 0);  check("lock_vfall3", locked, 1);
    check("line_len", line_len, HT);
    check("frame_lines", frame_lines, VT);

    // First captured frame.
    w0 = wr_cnt; f0 = fd_cnt;
    run_frame(VA, -1, -1, -1, 0);
    check("frame_write_count", wr_cnt - w0, HA * VA);
    check("frame_done_count", fd_cnt - f0, 1);
    check("frame_lines_locked", frame_lines, VT);

    // Line 3 stretched: lock drops at the next hfall (line 4 pixels already written).
    e0 = err_cnt;
    run_frame(5, 3, -1, -1, 0);
    check("err_pulses", err_cnt - e0, 1);
    check("unlocked_after_err", locked, 0);
    run_frame(0, -1, -1, -1, 0);  check("relock_pending", locked, 0);
    run_frame(0, -1, -1, -1, 0);  check("relocked", locked, 1);

    // Blank held one clock too long on line 2: 11th write suppressed, overflow sticky.
    run_frame(VA, -1, 2, -1, 0);

    // Constant-zero frame for CRC.
    run_frame(VA, -1, -1, -1, 1);
`ifdef VGA_CAPTURE_CRC_EN
    exp_crc = crc_zeros(HA * VA);
`else
    exp_crc = 16'h0000;
`endif
    check("frame_crc", frame_crc, exp_crc);

    // Reset mid-line at pixel (5,2); relock on the third vfall after release.
    run_frame(VA, -1, -1, 2, 0);  check("post_reset_vfall1", locked, 0);
    run_frame(0, -1, -1, -1, 0);  check("post_reset_vfall2", locked, 0);
    run_frame(0, -1, -1, -1, 0);  check("post_reset_vfall3", locked, 1);
    w0 = wr_cnt;
    run_frame(VA, -1, -1, -1, 0);
    check("final_write_count", wr_cnt - w0, HA * VA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
